wb_burst_ram: RTL

Synthesizable Wishbone B3 responder RAM with registered-feedback burst support (CTI/BTE). It is the slave end for the bus masters used against the SDRAM controller. It serves as an on-chip scratch/reference memory and as a drop-in stand-in for the SDRAM controller port in system benches. It supports single-beat classic cycles, incrementing bursts with linear or wrap-4/8/16 ordering, byte-lane writes, and error response outside its window.

---
 rtl/wb_burst_ram.sv | 134 +++++++++++++
 1 files changed

// File: rtl/wb_burst_ram.sv
// Wishbone B3 responder RAM with registered-feedback bursts (CTI/BTE).
// One wait state before the first ack; window errors flag the first beat only.
module wb_burst_ram #(
    parameter int              DW    = 32,
    parameter int              AW    = 32,
    parameter logic [AW-1:0]   BASE  = 32'h0000_0000,
    parameter int              DEPTH = 4096
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [AW-1:0]     wb_adr_i,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic [DW/8-1:0]   wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic [DW-1:0]     wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o
);

    localparam int         IW       = $clog2(DEPTH);
    localparam int         SW       = DW / 8;
    localparam logic [2:0] CTI_INCR = 3'b010;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d, rd_idx, idx, nxt;
    logic            in_win, beat, wr_en, ld_dat;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   mem [DEPTH];
    logic            unused_adr;

    // Wrap bursts keep the upper index bits and roll the low log2(N) bits.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] c, input logic [1:0] bte);
        logic [IW-1:0] mask;
        logic [IW-1:0] inc;
        case (bte)
            2'b01:   mask = IW'(3);
            2'b10:   mask = IW'(7);
            2'b11:   mask = IW'(15);
            default: mask = '1;
        endcase
        inc = c + 1'b1;
        return (c & ~mask) | (inc & mask);
    endfunction

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [SW-1:0] sel);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < SW; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    assign idx        = wb_adr_i[IW+1:2];
    assign in_win     = (wb_adr_i[AW-1:IW+2] == BASE[AW-1:IW+2]);
    assign beat       = wb_cyc_i & wb_stb_i;
    assign nxt        = next_idx(cnt_q, wb_bte_i);
    assign unused_adr = ^wb_adr_i[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_idx  = cnt_q;
        ld_dat  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (!in_win) begin
                        state_d = ERR;
                    end else begin
                        state_d = (wb_cti_i == CTI_INCR) ? BURST : SINGLE;
                        cnt_d   = idx;
                        rd_idx  = idx;
                        ld_dat  = 1'b1;
                    end
                end
            end
            SINGLE: begin
                state_d = IDLE;
                wr_en   = beat & wb_we_i;
            end
            BURST: begin
                if (!beat) begin
                    state_d = IDLE;
                end else begin
                    wr_en   = wb_we_i;
                    cnt_d   = nxt;
                    rd_idx  = nxt;
                    ld_dat  = 1'b1;
                    state_d = (wb_cti_i == CTI_INCR) ? BURST : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Forward the beat being written if the read targets the same word.
    always_comb begin
        rd_data = mem[rd_idx];
        if (wr_en && (rd_idx == cnt_q)) rd_data = lane_merge(rd_data, wb_dat_i, wb_sel_i);
    end

    always_ff @(posedge wb_clk_i) begin
        for (int b = 0; b < SW; b++) begin
            if (wr_en && wb_sel_i[b]) mem[cnt_q][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wb_ack_o <= (state_d == SINGLE) || (state_d == BURST);
            wb_err_o <= (state_d == ERR);
            if (ld_dat) wb_dat_o <= rd_data;
        end
    end

endmodule
